// File: rtl/cv32e41s_tbljmp_seq.sv
// Zcmt table-jump sequencer: fetches the jump-table entry for cm.jt/cm.jalt,
// produces the cleaned jump target and, for cm.jalt, the ra link write.
module cv32e41s_tbljmp_seq #(
  parameter int JVT_ADDR_WIDTH = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [JVT_ADDR_WIDTH-1:0] jvt_addr_i,
  input  logic [7:0]                jvt_index_i,
  input  logic [31:0]               pc_next_i,
  input  logic                      kill_i,
  output logic                      tbl_req_o,
  output logic [31:0]               tbl_addr_o,
  input  logic                      tbl_gnt_i,
  input  logic                      tbl_rvalid_i,
  input  logic [31:0]               tbl_rdata_i,
  input  logic                      tbl_err_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [31:0]               target_o,
  output logic                      link_we_o,
  output logic [31:0]               link_wdata_o,
  output logic                      fault_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, pc_q, target_q, link_wdata_q;
  logic        link_q, killed_q;
  logic [31:0] addr_d;
  logic        start_acc, rsp_ok;

  // Base is aligned, so the index offset is a plain add that wraps at 2^32.
  assign addr_d    = {jvt_addr_i, {(32-JVT_ADDR_WIDTH){1'b0}}} + {22'd0, jvt_index_i, 2'b00};
  assign start_acc = start_i && (state_q == IDLE);
  assign rsp_ok    = (state_q == WAIT) && tbl_rvalid_i && !tbl_err_i && !kill_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = REQ;
      REQ: begin
        if (tbl_gnt_i) state_d = (killed_q || kill_i) ? DROP : WAIT;
      end
      WAIT: begin
        if (kill_i)            state_d = tbl_rvalid_i ? IDLE : DROP;
        else if (tbl_rvalid_i) state_d = tbl_err_i ? IDLE : DONE;
      end
      DROP: if (tbl_rvalid_i) state_d = IDLE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pc_q         <= '0;
      link_q       <= 1'b0;
      killed_q     <= 1'b0;
      target_q     <= '0;
      link_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        addr_q   <= addr_d;
        pc_q     <= pc_next_i;
        link_q   <= (jvt_index_i >= 8'd32);
        killed_q <= 1'b0;
      end else if (state_q == REQ && kill_i) begin
        killed_q <= 1'b1;
      end
      // Target and link value only change on a clean response so they hold outside DONE.
      if (rsp_ok) begin
        target_q     <= {tbl_rdata_i[31:1], 1'b0};
        link_wdata_q <= pc_q;
      end
    end
  end

  assign tbl_req_o    = (state_q == REQ);
  assign tbl_addr_o   = addr_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign link_we_o    = (state_q == DONE) && link_q;
  assign target_o     = target_q;
  assign link_wdata_o = link_wdata_q;
  assign fault_o      = (state_q == WAIT) && tbl_rvalid_i && tbl_err_i && !kill_i;

  // A start while a sequence is in flight must not disturb the captured entry address.
  a_start_ignored: assert property (@(posedge clk) disable iff (!rst_n)
    (start_i && state_q != IDLE) |=> (tbl_addr_o == $past(tbl_addr_o)));

endmodule

// File: tb/tb_cv32e41s_tbljmp_seq.sv
// Bench for the Zcmt table-jump sequencer: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_cv32e41s_tbljmp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [25:0] jvt_addr_i;
  logic [7:0]  jvt_index_i;
  logic [31:0] pc_next_i;
  logic        kill_i;
  logic        tbl_req_o;
  logic [31:0] tbl_addr_o;
  logic        tbl_gnt_i;
  logic        tbl_rvalid_i;
  logic [31:0] tbl_rdata_i;
  logic        tbl_err_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] target_o;
  logic        link_we_o;
  logic [31:0] link_wdata_o;
  logic        fault_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: last delivered target and link value.
  logic [31:0] m_target = '0;
  logic [31:0] m_wdata  = '0;

  always #5 clk = ~clk;

  cv32e41s_tbljmp_seq #(.JVT_ADDR_WIDTH(26)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .jvt_addr_i   (jvt_addr_i),
    .jvt_index_i  (jvt_index_i),
    .pc_next_i    (pc_next_i),
    .kill_i       (kill_i),
    .tbl_req_o    (tbl_req_o),
    .tbl_addr_o   (tbl_addr_o),
    .tbl_gnt_i    (tbl_gnt_i),
    .tbl_rvalid_i (tbl_rvalid_i),
    .tbl_rdata_i  (tbl_rdata_i),
    .tbl_err_i    (tbl_err_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .target_o     (target_o),
    .link_we_o    (link_we_o),
    .link_wdata_o (link_wdata_o),
    .fault_o      (fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    start_i      = 1'b0;
    jvt_addr_i   = '0;
    jvt_index_i  = '0;
    pc_next_i    = '0;
    kill_i       = 1'b0;
    tbl_gnt_i    = 1'b0;
    tbl_rvalid_i = 1'b0;
    tbl_rdata_i  = '0;
    tbl_err_i    = 1'b0;
  endtask

  // One table jump. g: grant delay in REQ cycles; r: rvalid delay after grant (>=1).
  // kmode: 0 none, 1 kill in REQ cycle kc (0..g), 2 kill in WAIT cycle kc (1..r), 3 kill in DONE.
  // Entered and left at posedge+1.
  task automatic run_txn(input logic [25:0] base, input logic [7:0] idx, input logic [31:0] pc,
                         input logic [31:0] data, input bit err, input int g, input int r,
                         input int kmode, input int kc, input bit stray);
    logic [31:0] exp_addr;
    bit          killed, normal;
    int          rv_cyc, last_cyc;
    exp_addr = ({base, 6'd0} + {22'd0, idx, 2'b00}) & 32'hFFFF_FFFF;
    killed   = (kmode == 1) || (kmode == 2);
    normal   = !killed && !err;
    rv_cyc   = 1 + g + r;
    last_cyc = rv_cyc + (normal ? 1 : 0);
    for (int c = 0; c <= last_cyc + 1; c++) begin
      start_i      = (c == 0) || (stray && c == 2);
      jvt_addr_i   = (c == 0) ? base : 26'($urandom);
      jvt_index_i  = (c == 0) ? idx  : 8'($urandom);
      pc_next_i    = (c == 0) ? pc   : $urandom;
      tbl_gnt_i    = (c == 1 + g);
      tbl_rvalid_i = (c == rv_cyc);
      tbl_rdata_i  = (c == rv_cyc) ? data : $urandom;
      tbl_err_i    = (c == rv_cyc) ? err  : 1'($urandom);
      kill_i       = (kmode == 1 && c == 1 + kc) || (kmode == 2 && c == 1 + g + kc) ||
                     (kmode == 3 && c == last_cyc);
      @(negedge clk);
      if (normal && c == last_cyc) begin
        m_target = {data[31:1], 1'b0};
        m_wdata  = pc;
      end
      chk("busy",  32'(busy_o),    32'(c >= 1 && c <= last_cyc));
      chk("req",   32'(tbl_req_o), 32'(c >= 1 && c <= 1 + g));
      if (c >= 1 && c <= 1 + g) chk("addr", tbl_addr_o, exp_addr);
      chk("done",  32'(done_o),    32'(normal && c == last_cyc));
      chk("link_we", 32'(link_we_o), 32'(normal && c == last_cyc && idx >= 8'd32));
      chk("fault", 32'(fault_o),   32'(err && !killed && c == rv_cyc));
      chk("target", target_o, m_target);
      chk("link_wdata", link_wdata_o, m_wdata);
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    int kmode, kc, g, r;
    bit err;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_busy",   32'(busy_o), 0);
    chk("rst_req",    32'(tbl_req_o), 0);
    chk("rst_addr",   tbl_addr_o, 0);
    chk("rst_done",   32'(done_o), 0);
    chk("rst_target", target_o, 0);
    chk("rst_wdata",  link_wdata_o, 0);
    chk("rst_lwe",    32'(link_we_o), 0);
    chk("rst_fault",  32'(fault_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed scenarios
    run_txn(26'h0000100, 8'd5,   32'h0000_1234, 32'h0000_2A01, 1'b0, 0, 1, 0, 0, 1'b0);
    run_txn(26'h0000100, 8'd40,  32'h0000_8002, 32'h0000_3000, 1'b0, 4, 1, 0, 0, 1'b0);
    run_txn(26'h0000100, 8'd50,  32'h0000_9000, 32'h1111_2223, 1'b1, 1, 2, 0, 0, 1'b0);
    run_txn(26'h0000100, 8'd7,   32'h0000_A000, 32'h5555_5555, 1'b0, 2, 2, 1, 0, 1'b0);
    run_txn(26'h0000100, 8'd33,  32'h0000_B000, 32'h6666_6667, 1'b0, 1, 3, 2, 3, 1'b0);
    run_txn(26'h3FFFFFF, 8'd255, 32'h0000_C000, 32'h0000_7001, 1'b0, 0, 1, 0, 0, 1'b0);
    run_txn(26'h0000200, 8'd60,  32'h0000_D004, 32'h0000_ABCD, 1'b0, 1, 1, 3, 0, 1'b1);

    // Random transactions
    for (int t = 0; t < 200; t++) begin
      g     = $urandom_range(0, 4);
      r     = $urandom_range(1, 4);
      err   = ($urandom_range(0, 5) == 0);
      kmode = $urandom_range(0, 5);
      if (kmode > 3) kmode = 0;
      if (kmode == 3 && err) kmode = 0;
      kc = (kmode == 1) ? $urandom_range(0, g) : (kmode == 2) ? $urandom_range(1, r) : 0;
      run_txn(26'($urandom), 8'($urandom), $urandom, $urandom, err, g, r, kmode, kc,
              1'($urandom));
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        kill_i = 1'($urandom);
        @(negedge clk);
        chk("idle_busy", 32'(busy_o), 0);
        chk("idle_req",  32'(tbl_req_o), 0);
        @(posedge clk);
        #1 kill_i = 1'b0;
      end
    end

    // Asynchronous reset while waiting for the response
    start_i = 1'b1; jvt_addr_i = 26'h0000123; jvt_index_i = 8'd45; pc_next_i = 32'h0000_F00D;
    @(posedge clk); #1 start_i = 1'b0; tbl_gnt_i = 1'b1;
    @(posedge clk); #1 tbl_gnt_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    m_target = '0;
    m_wdata  = '0;
    chk("arst_busy",   32'(busy_o), 0);
    chk("arst_req",    32'(tbl_req_o), 0);
    chk("arst_addr",   tbl_addr_o, 0);
    chk("arst_done",   32'(done_o), 0);
    chk("arst_target", target_o, m_target);
    chk("arst_wdata",  link_wdata_o, m_wdata);
    chk("arst_lwe",    32'(link_we_o), 0);
    chk("arst_fault",  32'(fault_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn(26'h0000100, 8'd5, 32'h0000_0004, 32'h0000_2A01, 1'b0, 0, 1, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cv32e41s_tbljmp_seq.md
Name: cv32e41s_tbljmp_seq

Overview:
Sequencer for Zcmt table jumps (cm.jt / cm.jalt) issued from ID.
- Forms the jump-table entry address from the JVT base and the index.
- Fetches the entry over an OBI-style read port and cleans the returned pointer into the final jump target.
- On cm.jalt, also issues the ra link write and stalls ID until the sequence resolves.
- Sits between the ID-stage decoder/controller and the instruction-side bus arbiter.

Parameters:
JVT_ADDR_WIDTH, 26, number of upper JVT base bits; the low 32-JVT_ADDR_WIDTH bits of the base are zero.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  valid table-jump instruction in ID; single-cycle pulse
jvt_addr_i  input  JVT_ADDR_WIDTH  JVT CSR base field
jvt_index_i  input  8  table index from the instruction
pc_next_i  input  32  address of the instruction following the table jump
kill_i  input  1  flush of ID; abandons the sequence
tbl_req_o  output  1  read request
tbl_addr_o  output  32  table entry address
tbl_gnt_i  input  1  request granted
tbl_rvalid_i  input  1  response valid
tbl_rdata_i  input  32  table entry data
tbl_err_i  input  1  bus error; qualified by tbl_rvalid_i
busy_o  output  1  sequence in progress; stalls ID
done_o  output  1  one-cycle pulse: target_o is valid, redirect fetch
target_o  output  32  jump target
link_we_o  output  1  one-cycle pulse with done_o when index >= 32 (cm.jalt)
link_wdata_o  output  32  value written to ra
fault_o  output  1  one-cycle pulse: bus error on the table fetch

Behaviour:
- Reset values: state IDLE; all outputs 0, including tbl_addr_o, target_o and link_wdata_o.
- States: IDLE, REQ, WAIT, DROP, DONE.
- Address: tbl_addr_o = {jvt_addr_i, zeros} + {22'd0, jvt_index_i, 2'b00}; mod 2^32, no carry-out.
- Registered on start_i: address, link flag (jvt_index_i >= 32), pc_next_i.
- IDLE:
  - start_i moves to REQ next cycle.
  - start_i while not IDLE is ignored; covered by an assertion.
- REQ:
  - tbl_req_o = 1; tbl_addr_o is held stable until grant (OBI: no retraction).
  - tbl_gnt_i moves to WAIT, or to DROP if killed.
- WAIT:
  - tbl_rvalid_i with tbl_err_i = 0: capture target = {tbl_rdata_i[31:1], 1'b0}, then go to DONE.
  - tbl_rvalid_i with tbl_err_i = 1: pulse fault_o the same cycle, no link write, go to IDLE.
  - rvalid never arrives in the same cycle as gnt; at least 1 cycle later.
- DONE:
  - done_o = 1 for one cycle; target_o valid.
  - link_we_o = link flag; link_wdata_o = registered pc_next.
  - Next state IDLE.
- DROP: waits for tbl_rvalid_i, discards data and error, then goes to IDLE. No done_o, link_we_o or fault_o.
- busy_o = (state != IDLE). The start_i cycle itself is stalled by ID decode, not by this block.
- Kill:
  - kill_i in REQ sets a killed flag; tbl_req_o stays asserted until gnt, then DROP.
  - kill_i in WAIT goes to DROP; a response arriving in that same cycle is dropped and the state goes to IDLE.
  - kill_i in DONE does not suppress done_o; the controller gives the flush priority.
  - kill_i in IDLE has no effect.
- Simultaneous gnt and kill in REQ goes to DROP.
- At most one outstanding transaction.
- Minimum latency, start_i to done_o: 3 cycles (REQ+gnt, WAIT+rvalid, DONE).
- target_o and link_wdata_o hold their last values outside DONE.
- Reset mid-sequence returns to IDLE asynchronously; the bus side is reset concurrently.

Test Plan:
1. jvt_addr_i=26'h0000100 (base 0x4000), index=5, gnt the same cycle as req, rvalid 1 cycle later with data 0x0000_2A01:
   - tbl_addr_o=0x4014.
   - done_o 3 cycles after start_i, target_o=0x2A00, link_we_o=0.
2. index=40 (cm.jalt), pc_next_i=0x8002, base 0x4000, data 0x0000_3000, gnt delayed 4 cycles:
   - tbl_addr_o=0x40A0 stable for all 4 REQ cycles.
   - done_o with target_o=0x3000, link_we_o=1, link_wdata_o=0x8002.
3. Bus error: rvalid with tbl_err_i=1 -> fault_o pulse; no done_o or link_we_o; IDLE the next cycle.
4. kill_i during REQ with gnt 2 cycles later:
   - tbl_req_o held until gnt; response discarded.
   - No done_o or fault_o; busy_o low the cycle after rvalid.
5. kill_i in the same cycle as rvalid in WAIT -> no done_o; IDLE the next cycle.
6. Wrap-around and reset:
   - base 0xFFFFFFC0, index=255: tbl_addr_o=0x000003BC.
   - rst_n asserted in WAIT: busy_o=0 and all outputs 0 immediately.
